// File: rtl/serial_subtractor_pkg.sv
// Shared ALU definitions: sequencer state encoding and default operand width.
// The serial adder uses the same encoding so the ALU sequencer treats both cells alike.
package serial_subtractor_pkg;

   localparam int ALU_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell computing a - b - bin.
// The port order puts outputs first so it lines up with full_adder.
module full_subtractor (
   output logic diff,
   output logic borrow,
   input  logic a,
   input  logic b,
   input  logic bin
);

   // Difference bit and borrow-out for a single bit position.
   always_comb begin
      diff   = a ^ b ^ bin;
      borrow = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// Start/busy/done handshake; the result and flags are held from done until the next accepted start.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   alu_state_t       state_q;
   alu_state_t       state_d;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] diff_reg;
   logic             brw;
   logic             a_msb;
   logic             b_msb;
   logic             borrow_flag;
   logic             overflow_flag;
   logic             zero_flag;
   logic             cell_d;
   logic             cell_bout;
   logic             accept;

   full_subtractor u_cell (
      .diff   (cell_d),
      .borrow (cell_bout),
      .a      (a_sr[0]),
      .b      (b_sr[0]),
      .bin    (brw)
   );

   // A new operation is accepted whenever the unit is not busy.
   always_comb begin
      accept = 1'b0;
      if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
         accept = start;
      end
   end

   // State register; reset aborts any operation in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; RUN lasts WIDTH shift cycles plus one flag-capture cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt == LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Operand capture, bit-serial shifting and flag registration on the way into DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt           <= '0;
         a_sr          <= '0;
         b_sr          <= '0;
         diff_reg      <= '0;
         brw           <= 1'b0;
         a_msb         <= 1'b0;
         b_msb         <= 1'b0;
         borrow_flag   <= 1'b0;
         overflow_flag <= 1'b0;
         zero_flag     <= 1'b0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= b;
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
         brw   <= 1'b0;
         cnt   <= '0;
      end else if (state_q == ST_RUN) begin
         if (cnt != LAST) begin
            diff_reg <= {cell_d, diff_reg[WIDTH-1:1]};
            a_sr     <= a_sr >> 1;
            b_sr     <= b_sr >> 1;
            brw      <= cell_bout;
            cnt      <= cnt + CW'(1);
         end else begin
            borrow_flag   <= brw;
            overflow_flag <= (a_msb != b_msb) && (diff_reg[WIDTH-1] != a_msb);
            zero_flag     <= (diff_reg == '0);
         end
      end
   end

   // Handshake and result outputs come straight from registered state.
   always_comb begin
      busy       = (state_q == ST_RUN);
      done       = (state_q == ST_DONE);
      diff       = diff_reg;
      borrow_out = borrow_flag;
      overflow   = overflow_flag;
      zero       = zero_flag;
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed corner cases, random operands against
// an arithmetic reference, plus an exhaustive check of the full_subtractor cell.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         overflow;
   logic         zero;

   logic fs_a;
   logic fs_b;
   logic fs_bin;
   logic fs_d;
   logic fs_bo;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .overflow   (overflow),
      .zero       (zero)
   );

   full_subtractor u_fs (
      .diff   (fs_d),
      .borrow (fs_bo),
      .a      (fs_a),
      .b      (fs_b),
      .bin    (fs_bin)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer subtraction and signed range test.
   task automatic refModel(input logic [W-1:0] av, input logic [W-1:0] bv,
                           output logic [W-1:0] d, output logic br,
                           output logic ov, output logic z);
      int ua;
      int ub;
      int sa;
      int sb;
      int sd;
      ua = int'(av);
      ub = int'(bv);
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      sd = sa - sb;
      d  = W'((ua - ub + 256) % 256);
      br = (ua < ub);
      ov = (sd > 127) || (sd < -128);
      z  = (d == '0);
   endtask

   // Pulse start for one cycle, then wait (bounded) for done; lat counts cycles after the accepting edge.
   task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
      a     = av;
      b     = bv;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat   = 0;
      while ((done !== 1'b1) && (lat < 40)) begin
         tick();
         lat++;
      end
   endtask

   task automatic runOp(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
      int           lat;
      logic [W-1:0] ed;
      logic         eb;
      logic         eo;
      logic         ez;
      refModel(av, bv, ed, eb, eo, ez);
      applyStimulus(av, bv, lat);
      checkOutput({tag, "_latency"}, lat, W + 1);
      checkOutput({tag, "_diff"}, diff, ed);
      checkOutput({tag, "_borrow"}, borrow_out, eb);
      checkOutput({tag, "_overflow"}, overflow, eo);
      checkOutput({tag, "_zero"}, zero, ez);
   endtask

   initial begin
      int lat;
      int pulses;
      int r;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;

      // Full subtractor cell, all eight input combinations.
      for (int i = 0; i < 8; i++) begin
         fs_a   = i[2];
         fs_b   = i[1];
         fs_bin = i[0];
         #1;
         r = int'(fs_a) - int'(fs_b) - int'(fs_bin);
         checkOutput($sformatf("cell%0d_diff", i), fs_d, (r + 4) % 2);
         checkOutput($sformatf("cell%0d_borrow", i), fs_bo, (r < 0) ? 1 : 0);
      end

      // Reset state.
      tick();
      tick();
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_diff", diff, 0);
      checkOutput("rst_flags", {borrow_out, overflow, zero}, 0);
      rst = 1'b0;
      tick();

      // Directed cases.
      runOp("sub_5_3", 8'h05, 8'h03);
      tick();
      runOp("sub_3_5", 8'h03, 8'h05);
      tick();
      runOp("ovf_80_01", 8'h80, 8'h01);
      tick();
      runOp("ovf_7f_ff", 8'h7F, 8'hFF);
      tick();
      runOp("zero_a5", 8'hA5, 8'hA5);

      // Back-to-back: start issued in the done cycle.
      checkOutput("b2b_done_pulse", done, 1);
      runOp("b2b_10_01", 8'h10, 8'h01);
      tick();
      checkOutput("after_done_low", done, 0);

      // Start while busy must be ignored.
      a     = 8'h09;
      b     = 8'h04;
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("ign_busy", busy, 1);
      tick();
      tick();
      a     = 8'hFF;
      b     = 8'h00;
      start = 1'b1;
      tick();
      start = 1'b0;
      a     = 8'h00;
      lat   = 3;
      pulses = 0;
      for (int i = 0; i < 14; i++) begin
         if (done === 1'b1) begin
            if (pulses == 0) begin
               checkOutput("ign_latency", lat, W + 1);
               checkOutput("ign_diff", diff, 8'h05);
            end
            pulses++;
         end
         tick();
         lat++;
      end
      checkOutput("ign_pulses", pulses, 1);

      // Reset in the middle of an operation.
      a     = 8'h09;
      b     = 8'h04;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_diff", diff, 0);
      checkOutput("abort_flags", {borrow_out, overflow, zero}, 0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) pulses++;
         tick();
      end
      checkOutput("abort_pulses", pulses, 0);
      runOp("after_abort", 8'h09, 8'h04);

      // Random operands with random idle gaps (including none).
      for (int n = 0; n < 24; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         r  = int'($urandom_range(0, 2));
         for (int g = 0; g < r; g++) tick();
         runOp($sformatf("rand%0d", n), ra, rb);
      end

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
